// File: rtl/clk_div_ctrl_if.sv
// Ratio configuration handshake for clk_div_ctrl.
//   CFG_VALID : new ratio offered (master -> slave)
//   CFG_N     : requested ratio    (master -> slave)
//   CFG_READY : controller can accept a ratio (slave -> master)
//   CFG_ERR   : one-cycle pulse, previous transfer carried a ratio below 2
interface clk_div_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             CFG_VALID;
   logic [WIDTH-1:0] CFG_N;
   logic             CFG_READY;
   logic             CFG_ERR;

   modport master (output CFG_VALID, output CFG_N, input CFG_READY, input CFG_ERR);
   modport slave  (input CFG_VALID, input CFG_N, output CFG_READY, output CFG_ERR);
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock-divider controller. Produces a one-cycle TICK on the last
// cycle of every N-cycle period and a DIV_OUT level (high for ceil(N/2) cycles).
// Ratio changes arrive over the cfg handshake and take effect only at a period
// boundary; stopping always completes the period in progress.
//   CLK_IN  : sole clock, rising edge
//   REST    : synchronous active-high reset
//   ENABLE  : run (1) / stop (0) request
//   cfg     : ratio handshake (CFG_VALID, CFG_N, CFG_READY, CFG_ERR)
//   TICK    : last cycle of each period
//   DIV_OUT : divided-clock level
//   CUR_N   : ratio currently in effect
//   BUSY    : divider is counting (RUN, PEND, STOP)
//
// state  | meaning
// IDLE   | stopped, COUNT held at 0, ratio loads directly
// RUN    | counting, nothing pending
// PEND   | counting, new ratio waits for the next wrap
// STOP   | finishing the current period before halting
module clk_div_ctrl #(
   parameter int WIDTH     = 4,
   parameter int DEFAULT_N = 11
) (
   input  logic             CLK_IN,
   input  logic             REST,
   input  logic             ENABLE,
   clk_div_ctrl_if.slave    cfg,
   output logic             TICK,
   output logic             DIV_OUT,
   output logic [WIDTH-1:0] CUR_N,
   output logic             BUSY
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND, S_STOP} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] count, count_nxt;
   logic [WIDTH-1:0] cur_n_nxt;
   logic [WIDTH-1:0] pend_n, pend_n_nxt;
   logic             pend_vld, pend_vld_nxt;
   logic             cfg_err_nxt;
   logic             wrap, xfer, cfg_ok;
   logic [WIDTH:0]   half_n;

   assign BUSY          = (state != S_IDLE);
   assign wrap          = BUSY && (count == CUR_N - 1'b1);
   assign TICK          = wrap;
   // extra bit so N = 2^WIDTH-1 does not overflow when rounding up
   assign half_n        = ({1'b0, CUR_N} + 1'b1) >> 1;
   assign DIV_OUT       = BUSY && ({1'b0, count} < half_n);
   assign cfg.CFG_READY = (state != S_PEND);
   assign xfer          = cfg.CFG_VALID && cfg.CFG_READY;
   assign cfg_ok        = (cfg.CFG_N > WIDTH'(1));

   always_comb begin
      state_nxt    = state;
      count_nxt    = '0;
      cur_n_nxt    = CUR_N;
      pend_n_nxt   = pend_n;
      pend_vld_nxt = pend_vld;
      cfg_err_nxt  = xfer && !cfg_ok;

      if (BUSY && !wrap) begin
         count_nxt = count + 1'b1;
      end

      case (state)
         S_IDLE: begin
            if (xfer && cfg_ok) cur_n_nxt = cfg.CFG_N;
            if (ENABLE) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (xfer && cfg_ok) begin
               pend_n_nxt   = cfg.CFG_N;
               pend_vld_nxt = 1'b1;
               state_nxt    = S_PEND;
            end
            if (!ENABLE) state_nxt = S_STOP;
         end
         S_PEND: begin
            if (wrap) begin
               cur_n_nxt    = pend_n;
               pend_vld_nxt = 1'b0;
               state_nxt    = S_RUN;
            end
            if (!ENABLE) state_nxt = S_STOP;
         end
         S_STOP: begin
            if (wrap) begin
               // no later wrap exists, so a ratio arriving now lands directly
               state_nxt    = S_IDLE;
               pend_vld_nxt = 1'b0;
               if (xfer && cfg_ok) cur_n_nxt = cfg.CFG_N;
               else if (pend_vld)  cur_n_nxt = pend_n;
            end else begin
               if (xfer && cfg_ok) begin
                  pend_n_nxt   = cfg.CFG_N;
                  pend_vld_nxt = 1'b1;
               end
               if (ENABLE) state_nxt = pend_vld_nxt ? S_PEND : S_RUN;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK_IN) begin
      if (REST) begin
         state       <= S_IDLE;
         count       <= '0;
         CUR_N       <= WIDTH'(DEFAULT_N);
         pend_n      <= '0;
         pend_vld    <= 1'b0;
         cfg.CFG_ERR <= 1'b0;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         CUR_N       <= cur_n_nxt;
         pend_n      <= pend_n_nxt;
         pend_vld    <= pend_vld_nxt;
         cfg.CFG_ERR <= cfg_err_nxt;
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized bench for clk_div_ctrl against a period/phase reference model.
module tb_clk_div_ctrl;

   localparam int WIDTH     = 4;
   localparam int DEFAULT_N = 11;

   logic             CLK_IN = 1'b0;
   logic             REST;
   logic             ENABLE;
   logic             TICK;
   logic             DIV_OUT;
   logic [WIDTH-1:0] CUR_N;
   logic             BUSY;

   clk_div_ctrl_if #(.WIDTH(WIDTH)) cfg ();

   clk_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_N(DEFAULT_N)) dut (
      .CLK_IN  (CLK_IN),
      .REST    (REST),
      .ENABLE  (ENABLE),
      .cfg     (cfg.slave),
      .TICK    (TICK),
      .DIV_OUT (DIV_OUT),
      .CUR_N   (CUR_N),
      .BUSY    (BUSY)
   );

   always #5 CLK_IN = ~CLK_IN;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   // reference model: a divider is either halted or running through a period
   // of length cur; it may be winding down (stopping) and may hold a ratio
   // waiting for the end of the current period
   bit active, stopping, has_pend, m_err;
   int cur, pend, phase;

   function automatic bit m_ready();
      return !(active && !stopping && has_pend);
   endfunction

   task automatic m_reset();
      active = 0; stopping = 0; has_pend = 0; m_err = 0;
      cur = DEFAULT_N; pend = 0; phase = 0;
   endtask

   task automatic m_step(input bit rst, input bit en, input bit vld, input int n);
      bit xfer, good, period_end;
      if (rst) begin
         m_reset();
         return;
      end
      xfer       = vld && m_ready();
      good       = xfer && n >= 2;
      m_err      = xfer && n < 2;
      period_end = active && phase == cur - 1;
      if (!active) begin
         if (good) cur = n;
         if (en) begin active = 1; stopping = 0; end
         phase = 0;
      end else if (!stopping) begin
         if (has_pend && period_end) begin
            cur = pend; has_pend = 0;
         end else if (good) begin
            pend = n; has_pend = 1;
         end
         if (!en) stopping = 1;
         phase = period_end ? 0 : phase + 1;
      end else begin
         if (period_end) begin
            if (good) cur = n;
            else if (has_pend) cur = pend;
            has_pend = 0; active = 0; stopping = 0; phase = 0;
         end else begin
            if (good) begin pend = n; has_pend = 1; end
            if (en) stopping = 0;
            phase = phase + 1;
         end
      end
   endtask

   task automatic check_all();
      chk("tick",  int'(TICK),          int'(active && phase == cur - 1));
      chk("div",   int'(DIV_OUT),       int'(active && phase < (cur + 1) / 2));
      chk("busy",  int'(BUSY),          int'(active));
      chk("ready", int'(cfg.CFG_READY), int'(m_ready()));
      chk("err",   int'(cfg.CFG_ERR),   int'(m_err));
      chk("cur_n", int'(CUR_N),         cur);
   endtask

   task automatic cycle(input bit rst, input bit en, input bit vld, input int n);
      REST          = rst;
      ENABLE        = en;
      cfg.CFG_VALID = vld;
      cfg.CFG_N     = WIDTH'(n);
      @(posedge CLK_IN);
      m_step(rst, en, vld, n);
      @(negedge CLK_IN);
      check_all();
   endtask

   initial begin
      bit en;
      bit vld;
      int n;
      m_reset();
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      chk("rst_cur", int'(CUR_N), DEFAULT_N);
      chk("rst_ready", int'(cfg.CFG_READY), 1);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

      // default ratio free-running, then a mid-period change to 4
      for (int i = 0; i < 30; i++) cycle(0, 1, 0, 0);
      cycle(0, 1, 1, 4);
      for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0);
      // rejected ratios
      cycle(0, 1, 1, 1);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 1, 0);
      for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0);
      // graceful stop
      for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0);

      en = 1;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 24) == 0) en = !en;
         vld = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 4) == 0) n = int'($urandom_range(0, 1));
         else                           n = int'($urandom_range(2, 15));
         cycle($urandom_range(0, 499) == 0, en, vld, n);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
